// File: rtl/dds_pkg.sv
// Shared DDS constants, sample type and the quarter-wave sine table.
// The table is generated at elaboration with a Q62 fixed-point Taylor series.
package dds_pkg;

  localparam int DDS_ADDR_W    = 10;
  localparam int DDS_DATA_W    = 16;
  localparam int DDS_AMPLITUDE = 32767;

  typedef logic signed [15:0] dds_sample_t;
  typedef logic [0:256][14:0] dds_qtab_t;

  localparam logic [63:0] DDS_PI_Q62 = 64'hC90FDAA22168C234;
  localparam logic [63:0] DDS_BIAS   = 64'h0000_0000_0001_0000;

  function automatic dds_qtab_t dds_build_qtab();
    dds_qtab_t    t;
    logic [127:0] x;
    logic [127:0] x2;
    logic [127:0] term;
    logic [127:0] sum;
    logic [127:0] mag;
    t = '0;
    for (int k = 0; k <= 256; k++) begin
      x    = (128'(DDS_PI_Q62) * 128'(k)) >> 9;
      x2   = (x * x) >> 62;
      term = x;
      sum  = x;
      for (int n = 3; n <= 31; n += 2) begin
        term = ((term * x2) >> 62) / 128'((n - 1) * n);
        if (n % 4 == 3)
          sum = sum - term;
        else
          sum = sum + term;
      end
      // Bias offsets floor drift; the exact peak is pinned explicitly.
      mag = ((sum + 128'(DDS_BIAS))
             * 128'(DDS_AMPLITUDE)) >> 62;
      if (k == 256)
        t[k] = 15'(DDS_AMPLITUDE);
      else
        t[k] = mag[14:0];
    end
    return t;
  endfunction

  localparam dds_qtab_t DDS_QSIN = dds_build_qtab();

endpackage

// File: rtl/dds_quarter_sin_lut.sv
// Combinational quarter-wave lookup: index 0..256 to
// unsigned 15-bit magnitude.
module dds_quarter_sin_lut
  import dds_pkg::*;
(
  input  logic [8:0]  idx,
  output logic [14:0] mag
);

  always_comb begin
    mag = '0;
    if (idx <= 9'd256)
      mag = DDS_QSIN[idx];
  end

endmodule

// File: rtl/dds_sin_rom.sv
// Full-period sine ROM: quadrant fold over the quarter table,
// sign applied, one registered output stage.
module dds_sin_rom
  import dds_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DDS_ADDR_W-1:0] address,
  output logic [DDS_DATA_W-1:0] q
);

  logic [1:0]  quad;
  logic [7:0]  phase;
  logic [8:0]  idx;
  logic [14:0] mag;
  dds_sample_t pos;
  dds_sample_t sample;

  assign quad  = address[9:8];
  assign phase = address[7:0];

  // Odd quadrants run the table backwards; i=0 there maps to T[256].
  assign idx = quad[0] ? (9'd256 - {1'b0, phase})
                       : {1'b0, phase};

  dds_quarter_sin_lut u_lut (
    .idx (idx),
    .mag (mag)
  );

  assign pos    = {1'b0, mag};
  assign sample = quad[1] ? -pos : pos;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      q <= '0;
    else
      q <= sample;
  end

endmodule

// File: tb/tb_dds_sin_rom.sv
// Directed and model-based checks for the DDS sine ROM.
// Inputs change after rising edges; q is sampled 1 time unit after.
module tb_dds_sin_rom;

  logic        clk;
  logic        reset;
  logic [9:0]  address;
  logic [15:0] q;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] got [1024];

  dds_sin_rom dut (
    .clk     (clk),
    .reset   (reset),
    .address (address),
    .q       (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ref_q(int a);
    real v;
    v = 32767.0 * $sin(2.0 * 3.141592653589793 * a / 1024.0);
    return 16'($rtoi(v));
  endfunction

  task automatic step_and_check(input logic [9:0] a,
                                input logic [15:0] exp,
                                input string name);
    address = a;
    @(posedge clk);
    #1;
    n_cmp++;
    if (q !== exp) begin
      n_err++;
      $display("FAIL %s a=%0d got %h want %h", name, a, q, exp);
    end
  endtask

  task automatic test_reset();
    reset   = 1'b0;
    address = 10'd5;
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (q !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_hold got %h want 0000", q);
    end
    @(negedge clk);
    reset = 1'b0;
    step_and_check(10'd5, 16'h03ED, "reset_release");
    step_and_check(10'd100, ref_q(100), "pre_async");
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (q !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_async got %h want 0000", q);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (q !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_held_edge got %h want 0000", q);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_latency();
    step_and_check(10'd0,  16'h0000, "lat_a0");
    step_and_check(10'd5,  16'h03ED, "lat_a5");
    step_and_check(10'd10, 16'h07D9, "lat_a10");
    step_and_check(10'd15, 16'h0BC3, "lat_a15");
  endtask

  task automatic test_boundaries();
    step_and_check(10'd256,  16'h7FFF, "bnd_a256");
    step_and_check(10'd512,  16'h0000, "bnd_a512");
    step_and_check(10'd768,  16'h8001, "bnd_a768");
    step_and_check(10'd1023, 16'hFF37, "bnd_a1023");
    step_and_check(10'd0,    16'h0000, "bnd_wrap0");
    step_and_check(10'd1,    16'h00C9, "bnd_a1");
  endtask

  task automatic test_sweep();
    for (int a = 0; a < 1024; a++) begin
      step_and_check(10'(a), ref_q(a), "sweep");
      got[a] = q;
    end
    for (int a = 1; a < 512; a++) begin
      n_cmp++;
      if (got[a] !== got[512 - a]) begin
        n_err++;
        $display("FAIL sym_mirror a=%0d got %h want %h",
                 a, got[a], got[512 - a]);
      end
    end
    for (int a = 0; a < 512; a++) begin
      n_cmp++;
      if (got[a + 512] !== 16'(-got[a])) begin
        n_err++;
        $display("FAIL sym_neg a=%0d got %h want %h",
                 a + 512, got[a + 512], 16'(-got[a]));
      end
    end
    for (int a = 0; a < 1024; a++) begin
      n_cmp++;
      if (got[a] === 16'h8000) begin
        n_err++;
        $display("FAIL no_8000 a=%0d got %h want not 8000",
                 a, got[a]);
      end
    end
  endtask

  task automatic test_stream();
    logic [31:0] acc;
    int          mx;
    int          mn;
    acc = 32'h0;
    mx  = -40000;
    mn  = 40000;
    for (int c = 0; c < 400; c++) begin
      step_and_check(acc[31:22], ref_q(int'(acc[31:22])), "stream");
      if ($signed(q) > mx) mx = $signed(q);
      if ($signed(q) < mn) mn = $signed(q);
      acc = acc + 32'h0147AEB8;
    end
    n_cmp++;
    if (mx < 32760) begin
      n_err++;
      $display("FAIL stream_peak got %0d want >=32760", mx);
    end
    n_cmp++;
    if (mn > -32760) begin
      n_err++;
      $display("FAIL stream_trough got %0d want <=-32760", mn);
    end
  endtask

  task automatic test_reset_midstream();
    logic [31:0] acc;
    acc = 32'h1000_0000;
    for (int c = 0; c < 60; c++) begin
      step_and_check(acc[31:22], ref_q(int'(acc[31:22])), "mid_pre");
      acc = acc + 32'h0147AEB8;
      if (c == 30) begin
        address = acc[31:22];
        #1 reset = 1'b1;
        #1;
        n_cmp++;
        if (q !== 16'h0000) begin
          n_err++;
          $display("FAIL mid_reset got %h want 0000", q);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (q !== ref_q(int'(acc[31:22]))) begin
          n_err++;
          $display("FAIL mid_resume a=%0d got %h want %h",
                   acc[31:22], q, ref_q(int'(acc[31:22])));
        end
        acc = acc + 32'h0147AEB8;
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_boundaries();
    test_sweep();
    test_stream();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
